ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Parametrised hardware return-address stack for the pipelined core.
- Pushed on CALL with the return PC (IF_ID pc + 1); popped on RET. Its top feeds the pc_mux RET input combinationally.
- Generalises the fixed stack: configurable width and depth, full/empty/count status, selectable overflow policy, same-cycle push+pop, flush, and sticky error flags for the hazard/controller logic.

Parameters:
- WIDTH, 12, bit width of a stored address (matches PC width).
- DEPTH, 8, number of entries; legal values are DEPTH >= 2, not necessarily a power of two.
- OVF_MODE, 0, full-push policy: 0 = reject (saturate), 1 = wrap (overwrite oldest entry).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  push push_data this cycle.
- pop  in  1  pop the top entry this cycle.
- flush  in  1  empty the stack (pipeline flush / context reset).
- clr_err  in  1  clear the sticky overflow/underflow flags.
- push_data  in  WIDTH  address to push.
- top  out  WIDTH  current top entry; combinational from registers; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (reset low, async): wr_ptr=0, count=0, overflow=0, underflow=0. Therefore top=0, empty=1, full=0. Storage array is not reset.
- Storage is a circular array of DEPTH entries.
  - wr_ptr indexes the next free slot.
  - top = mem[(wr_ptr-1) mod DEPTH] when count>0, else 0.
  - Pointer arithmetic wraps explicitly at DEPTH; no reliance on power-of-two truncation.
- Latency: a push is visible on top the cycle after the clock edge. A pop exposes the previous entry the cycle after the edge. Within the cycle of the operation, top shows the pre-operation value.
- Operation priority each posedge (reset not asserted):
  1. flush=1: count=0, wr_ptr unchanged; push/pop ignored; error flags keep their value (clr_err still applies).
  2. push=1, pop=0, not full: mem[wr_ptr]=push_data, wr_ptr++, count++.
  3. push=1, pop=0, full, OVF_MODE=0: no state change; overflow=1.
  4. push=1, pop=0, full, OVF_MODE=1: mem[wr_ptr]=push_data, wr_ptr++, count stays DEPTH (oldest entry lost); overflow=1.
  5. pop=1, push=0, count>0: wr_ptr--, count--.
  6. pop=1, push=0, empty: no change; underflow=1.
  7. push=1, pop=1, count>0: replace top, i.e. mem[wr_ptr-1]=push_data; wr_ptr and count unchanged; no error in any mode, including when full.
  8. push=1, pop=1, empty: behaves as a plain push (count becomes 1); underflow=1.
- Sticky flags:
  - clr_err=1 clears both flags at the edge.
  - If a new error occurs in the same cycle, that flag ends at 1 (set wins over clear).
- Reset asserted mid-operation aborts any push/pop immediately. No partial write is visible after release.
- count, empty and full are registered-state derived; no combinational path from push/pop to status outputs.

Decomposition:
- Shared package holds:
  - OVF_SATURATE=0 and OVF_WRAP=1 constants.
  - A ptr_inc/ptr_dec modulo-DEPTH helper function, reused by the future branch-history buffer.
- One natural sub-module: ras_storage, the DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
- Pointer/count/flag control stays in ret_addr_stack.

Test Plan (WIDTH=12, DEPTH=4 unless noted):
- Reset then idle -> top=0, count=0, empty=1, full=0, overflow=0, underflow=0. Assert reset mid-cycle after 2 pushes -> count=0 immediately (async).
- Push 0x101, 0x102, 0x103 -> top=0x103, count=3. Pop x2 -> top=0x101, count=1. Pop -> empty=1, top=0.
- OVF_MODE=0: push 0x201..0x204, then push 0x205 -> full=1, overflow=1, top=0x204. Pop x4 returns 0x204, 0x203, 0x202, 0x201.
- OVF_MODE=1: push 0x301..0x305 -> overflow=1, count=4, top=0x305. Pop x4 returns 0x305, 0x304, 0x303, 0x302; then empty=1.
- Push 0x401, then push+pop with 0x4AA -> count=1, top=0x4AA, no flags. Push+pop while empty with 0x4BB -> count=1, top=0x4BB, underflow=1.
- Pop while empty and clr_err in the same cycle -> underflow=1. Next cycle clr_err alone -> underflow=0. Flush with count=3 and push=1 -> count=0, top=0, push ignored.

Source files
------------

// File: rtl/ret_addr_stack_pkg.sv
// Shared constants and modulo-DEPTH pointer helpers for the return-address stack
// and related circular buffers.
package ret_addr_stack_pkg;

  localparam int unsigned OVF_SATURATE = 0;
  localparam int unsigned OVF_WRAP     = 1;

  // Explicit wrap at depth so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 32'd0) ? depth - 32'd1 : ptr - 32'd1;
  endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Request/status bundle between the pipeline controller and the return-address stack.
interface ret_addr_stack_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) ();

  logic                       push;
  logic                       pop;
  logic                       flush;
  logic                       clr_err;
  logic [WIDTH-1:0]           push_data;
  logic [WIDTH-1:0]           top;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output push, pop, flush, clr_err, push_data,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err, push_data,
    output top, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/ret_addr_stack_ras_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module ras_storage #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PtrW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PtrW-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Parametrised return-address stack: circular storage with count/flag control,
// configurable full-push policy and same-cycle push+pop replace.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = OVF_SATURATE
) (
  input logic             clk_i,
  input logic             rst_ni,
  ret_addr_stack_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [PtrW-1:0]  mem_waddr;
  logic [PtrW-1:0]  top_idx;
  logic [PtrW-1:0]  wr_ptr_inc;
  logic [PtrW-1:0]  wr_ptr_dec;
  logic [WIDTH-1:0] mem_rdata;
  logic             is_empty;
  logic             is_full;

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CntW'(DEPTH));
  assign wr_ptr_inc = PtrW'(ptr_inc(32'(wr_ptr_q), DEPTH));
  assign wr_ptr_dec = PtrW'(ptr_dec(32'(wr_ptr_q), DEPTH));
  assign top_idx    = wr_ptr_dec;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;

    if (bus.flush) begin
      count_d = '0;
    end else begin
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (!is_full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            count_d  = count_q + CntW'(1);
          end else begin
            overflow_d = 1'b1;
            // When full, wr_ptr already addresses the oldest entry.
            if (OVF_MODE == OVF_WRAP) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_inc;
            end
          end
        end
        2'b01: begin
          if (!is_empty) begin
            wr_ptr_d = wr_ptr_dec;
            count_d  = count_q - CntW'(1);
          end else begin
            underflow_d = 1'b1;
          end
        end
        2'b11: begin
          mem_we = 1'b1;
          if (!is_empty) begin
            mem_waddr = top_idx;
          end else begin
            wr_ptr_d    = wr_ptr_inc;
            count_d     = CntW'(1);
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ras_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (bus.push_data),
    .raddr_i (top_idx),
    .rdata_o (mem_rdata)
  );

  assign bus.top       = is_empty ? '0 : mem_rdata;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench: saturate-mode and wrap-mode stacks (DEPTH=4) driven with identical stimulus.
module tb_ret_addr_stack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ret_addr_stack_if #(.WIDTH(12), .DEPTH(4)) if0 ();
  ret_addr_stack_if #(.WIDTH(12), .DEPTH(4)) if1 ();

  ret_addr_stack #(.WIDTH(12), .DEPTH(4), .OVF_MODE(0)) dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if0)
  );

  ret_addr_stack #(.WIDTH(12), .DEPTH(4), .OVF_MODE(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ps, input logic pp, input logic fl, input logic ce,
                       input logic [11:0] d);
    if0.push = ps; if0.pop = pp; if0.flush = fl; if0.clr_err = ce; if0.push_data = d;
    if1.push = ps; if1.pop = pp; if1.flush = fl; if1.clr_err = ce; if1.push_data = d;
  endtask

  // One clock with the given request, sampled #1 after the edge.
  task automatic op(input logic ps, input logic pp, input logic fl, input logic ce,
                    input logic [11:0] d);
    drive(ps, pp, fl, ce, d);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic st(input string tag, input int m, input logic [11:0] etop, input int ecnt);
    if (m == 0) begin
      check({tag, "/top0"}, {20'd0, if0.top}, {20'd0, etop});
      check({tag, "/cnt0"}, 32'(if0.count), 32'(ecnt));
    end else begin
      check({tag, "/top1"}, {20'd0, if1.top}, {20'd0, etop});
      check({tag, "/cnt1"}, 32'(if1.count), 32'(ecnt));
    end
  endtask

  task automatic flags(input string tag, input int m, input logic eo, input logic eu);
    if (m == 0) begin
      check({tag, "/ovf0"}, 32'(if0.overflow), 32'(eo));
      check({tag, "/udf0"}, 32'(if0.underflow), 32'(eu));
    end else begin
      check({tag, "/ovf1"}, 32'(if1.overflow), 32'(eo));
      check({tag, "/udf1"}, 32'(if1.underflow), 32'(eu));
    end
  endtask

  // Push base+1..base+5 into a 4-deep stack, then drain and compare per policy.
  task automatic ovf_test(input logic [11:0] base);
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 1'b0, 1'b0, base + 12'(i));
    check("ovf/full0", 32'(if0.full), 32'd1);
    check("ovf/full1", 32'(if1.full), 32'd1);
    flags("ovf/pre", 0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 1'b0, 1'b0, base + 12'd5);
    st("ovf/post", 0, base + 12'd4, 4);
    st("ovf/post", 1, base + 12'd5, 4);
    flags("ovf/post", 0, 1'b1, 1'b0);
    flags("ovf/post", 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      st("ovf/drain", 0, base + 12'(4 - i), 4 - i);
      st("ovf/drain", 1, base + 12'(5 - i), 4 - i);
      op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    end
    check("ovf/empty0", 32'(if0.empty), 32'd1);
    check("ovf/empty1", 32'(if1.empty), 32'd1);
    op(1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    flags("ovf/clr", 0, 1'b0, 1'b0);
    flags("ovf/clr", 1, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      st("reset", m, 12'h0, 0);
      flags("reset", m, 1'b0, 1'b0);
    end
    check("reset/empty0", 32'(if0.empty), 32'd1);
    check("reset/full0", 32'(if0.full), 32'd0);
    check("reset/full1", 32'(if1.full), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h0A1);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h0A2);
    st("pre_arst", 0, 12'h0A2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    st("arst", 0, 12'h0, 0);
    st("arst", 1, 12'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic LIFO order.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h101);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h102);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h103);
    st("push3", 0, 12'h103, 3);
    st("push3", 1, 12'h103, 3);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    st("pop2", 0, 12'h101, 1);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    st("pop3", 0, 12'h0, 0);
    check("pop3/empty1", 32'(if1.empty), 32'd1);
    flags("pop3", 0, 1'b0, 1'b0);

    ovf_test(12'h200);
    ovf_test(12'h300);

    // Push+pop when full replaces the top and raises no error.
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 1'b0, 1'b0, 12'h700 + 12'(i));
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'h7AA);
    st("full_rep", 0, 12'h7AA, 4);
    st("full_rep", 1, 12'h7AA, 4);
    flags("full_rep", 0, 1'b0, 1'b0);
    flags("full_rep", 1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    st("full_rep_pop", 0, 12'h703, 3);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h0);
    st("flush_a", 0, 12'h0, 0);

    // Replace on non-empty, then push+pop on empty.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h401);
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'h4AA);
    st("replace", 0, 12'h4AA, 1);
    flags("replace", 0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    st("replace_pop", 0, 12'h0, 0);
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'h4BB);
    st("pp_empty", 0, 12'h4BB, 1);
    st("pp_empty", 1, 12'h4BB, 1);
    flags("pp_empty", 0, 1'b0, 1'b1);

    // Set wins over clear; clear alone drops the flag.
    op(1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    flags("clr", 0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    op(1'b0, 1'b1, 1'b0, 1'b1, 12'h0);
    flags("set_clr", 0, 1'b0, 1'b1);
    flags("set_clr", 1, 1'b0, 1'b1);
    op(1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    flags("clr2", 0, 1'b0, 1'b0);

    // Flush beats a simultaneous push.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h501);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h502);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h503);
    st("pre_flush", 0, 12'h503, 3);
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'h5FF);
    st("flush", 0, 12'h0, 0);
    st("flush", 1, 12'h0, 0);
    check("flush/empty0", 32'(if0.empty), 32'd1);
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h601);
    st("after_flush", 0, 12'h601, 1);
    st("after_flush", 1, 12'h601, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
